// File: rtl/farol_pkg.sv
// Shared types and helpers for the timed headlight-on warning.
// State codes, default timing constants and the warning condition.
package farol_pkg;

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      CONFIRMA = 3'd1,
      BIPANDO  = 3'd2,
      SILENCIO = 3'd3,
      DESLIGA  = 3'd4
   } estado_t;

   localparam int N_LUZES_DEF    = 2;
   localparam int TICK_DIV_DEF   = 50000;
   localparam int T_CONFIRMA_DEF = 20;
   localparam int T_BIP_ON_DEF   = 5;
   localparam int T_BIP_OFF_DEF  = 5;
   localparam int T_LIMITE_DEF   = 600;

   // Any light on while the door is open or the key is out.
   function automatic logic cond_alerta(
      input logic luz,
      input logic porta,
      input logic chave
   );
      return luz & ~(porta & chave);
   endfunction

endpackage

// File: rtl/gerador_tick.sv
// Prescaler: one-cycle tick every TICK_DIV cycles, synchronous clear.
// Ports: clk, rst_n (sync, active-low), clr, tick.
module gerador_tick #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int W = $clog2(TICK_DIV);
   localparam logic [W-1:0] MAX = W'(TICK_DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (cnt == MAX) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == MAX);

endmodule

// File: rtl/sinalizador_farol_temporizado.sv
// Timed headlight-on warning: confirm, pulsed beep, silence, auto-off.
// Ports: clk, rst_n, farol, porta, chave, silenciar -> saida, alerta, desliga_luz, estado.
module sinalizador_farol_temporizado
   import farol_pkg::*;
#(
   parameter int N_LUZES    = N_LUZES_DEF,
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int T_CONFIRMA = T_CONFIRMA_DEF,
   parameter int T_BIP_ON   = T_BIP_ON_DEF,
   parameter int T_BIP_OFF  = T_BIP_OFF_DEF,
   parameter int T_LIMITE   = T_LIMITE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_LUZES-1:0] farol,
   input  logic               porta,
   input  logic               chave,
   input  logic               silenciar,
   output logic               saida,
   output logic               alerta,
   output logic [N_LUZES-1:0] desliga_luz,
   output logic [2:0]         estado
);

   localparam int T_MAX1 = (T_CONFIRMA > T_BIP_ON) ? T_CONFIRMA : T_BIP_ON;
   localparam int T_MAX  = (T_MAX1 > T_BIP_OFF) ? T_MAX1 : T_BIP_OFF;
   localparam int TW     = $clog2(T_MAX + 1);
   localparam int L_MAX  = (T_LIMITE > 0) ? T_LIMITE : 1;
   localparam int LW     = $clog2(L_MAX + 1);

   localparam logic [TW-1:0] FIM_CONF = TW'(T_CONFIRMA - 1);
   localparam logic [TW-1:0] FIM_ON   = TW'(T_BIP_ON - 1);
   localparam logic [TW-1:0] FIM_OFF  = TW'(T_BIP_OFF - 1);
   localparam logic [LW-1:0] FIM_LIM  = LW'(L_MAX - 1);

   estado_t             state, state_n;
   logic                fase, fase_n;
   logic [TW-1:0]       tcnt, tcnt_n;
   logic [LW-1:0]       lcnt, lcnt_n;
   logic                troca_fase;
   logic                clr, tick, c;
   logic                saida_n, alerta_n;
   logic [N_LUZES-1:0]  desliga_n;
   logic [TW-1:0]       fim_fase;

   assign c        = cond_alerta(|farol, porta, chave);
   assign fim_fase = fase ? FIM_ON : FIM_OFF;
   // Restarting the prescaler keeps every interval an exact tick multiple.
   assign clr      = (state_n != state) | troca_fase;

   gerador_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   always_comb begin
      state_n    = state;
      fase_n     = fase;
      tcnt_n     = tcnt;
      lcnt_n     = lcnt;
      troca_fase = 1'b0;

      unique case (state)
         OCIOSO: begin
            if (c) state_n = CONFIRMA;
         end
         CONFIRMA: begin
            if (tick) begin
               if (tcnt == FIM_CONF) state_n = BIPANDO;
               else tcnt_n = tcnt + 1'b1;
            end
         end
         BIPANDO: begin
            if (silenciar) begin
               state_n = SILENCIO;
            end else if (T_LIMITE != 0 && tick && lcnt == FIM_LIM) begin
               state_n = DESLIGA;
            end else if (tick) begin
               if (T_LIMITE != 0) lcnt_n = lcnt + 1'b1;
               if (tcnt == fim_fase) begin
                  fase_n     = ~fase;
                  tcnt_n     = '0;
                  troca_fase = 1'b1;
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
         end
         SILENCIO, DESLIGA: ;
         default: state_n = OCIOSO;
      endcase

      // Losing the condition overrides everything else.
      if (state != OCIOSO && !c) state_n = OCIOSO;

      if (state_n != state) begin
         tcnt_n = '0;
         lcnt_n = '0;
         fase_n = (state_n == BIPANDO);
      end
   end

   always_comb begin
      saida_n   = (state_n == BIPANDO) && fase_n;
      alerta_n  = (state_n == BIPANDO) ||
                  (state_n == SILENCIO) ||
                  (state_n == DESLIGA);
      desliga_n = '0;
      // Snapshot on entry; later channels are not requested.
      if (state_n == DESLIGA) begin
         desliga_n = (state == DESLIGA) ? desliga_luz : farol;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= OCIOSO;
         fase        <= 1'b0;
         tcnt        <= '0;
         lcnt        <= '0;
         saida       <= 1'b0;
         alerta      <= 1'b0;
         desliga_luz <= '0;
      end else begin
         state       <= state_n;
         fase        <= fase_n;
         tcnt        <= tcnt_n;
         lcnt        <= lcnt_n;
         saida       <= saida_n;
         alerta      <= alerta_n;
         desliga_luz <= desliga_n;
      end
   end

   assign estado = state;

endmodule

// File: tb/tb_sinalizador_farol_temporizado.sv
// Directed bench for the timed headlight-on warning.
// Small timing parameters so every scenario fits in a few dozen edges.
module tb_sinalizador_farol_temporizado;

   logic       clk;
   logic       rst_n;
   logic [1:0] farol;
   logic       porta;
   logic       chave;
   logic       silenciar;
   logic       saida;
   logic       alerta;
   logic [1:0] desliga_luz;
   logic [2:0] estado;

   int n_cmp = 0;
   int n_err = 0;

   sinalizador_farol_temporizado #(
      .N_LUZES    (2),
      .TICK_DIV   (4),
      .T_CONFIRMA (2),
      .T_BIP_ON   (1),
      .T_BIP_OFF  (1),
      .T_LIMITE   (6)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .farol       (farol),
      .porta       (porta),
      .chave       (chave),
      .silenciar   (silenciar),
      .saida       (saida),
      .alerta      (alerta),
      .desliga_luz (desliga_luz),
      .estado      (estado)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; farol = 2'b11; porta = 1'b0;
      chave = 1'b1; silenciar = 1'b0;
      step(3);
      n_cmp++; if (saida !== 1'b0) begin n_err++; $display("FAIL rst_saida got %0h want 0", saida); end
      n_cmp++; if (alerta !== 1'b0) begin n_err++; $display("FAIL rst_alerta got %0h want 0", alerta); end
      n_cmp++; if (desliga_luz !== 2'b00) begin n_err++; $display("FAIL rst_desliga got %0h want 0", desliga_luz); end
      n_cmp++; if (estado !== 3'd0) begin n_err++; $display("FAIL rst_estado got %0d want 0", estado); end
   endtask

   task automatic test_beep_limit();
      farol = 2'b01; porta = 1'b0; chave = 1'b1; rst_n = 1'b1;
      step(1);
      n_cmp++; if (estado !== 3'd1) begin n_err++; $display("FAIL e1_estado got %0d want 1", estado); end
      n_cmp++; if (alerta !== 1'b0) begin n_err++; $display("FAIL e1_alerta got %0h want 0", alerta); end
      step(7);
      n_cmp++; if (estado !== 3'd1) begin n_err++; $display("FAIL e8_estado got %0d want 1", estado); end
      n_cmp++; if (saida !== 1'b0) begin n_err++; $display("FAIL e8_saida got %0h want 0", saida); end
      step(1);
      n_cmp++; if (estado !== 3'd2) begin n_err++; $display("FAIL e9_estado got %0d want 2", estado); end
      n_cmp++; if (alerta !== 1'b1) begin n_err++; $display("FAIL e9_alerta got %0h want 1", alerta); end
      n_cmp++; if (saida !== 1'b1) begin n_err++; $display("FAIL e9_saida got %0h want 1", saida); end
      step(3);
      n_cmp++; if (saida !== 1'b1) begin n_err++; $display("FAIL e12_saida got %0h want 1", saida); end
      step(1);
      n_cmp++; if (saida !== 1'b0) begin n_err++; $display("FAIL e13_saida got %0h want 0", saida); end
      step(3);
      n_cmp++; if (saida !== 1'b0) begin n_err++; $display("FAIL e16_saida got %0h want 0", saida); end
      step(1);
      n_cmp++; if (saida !== 1'b1) begin n_err++; $display("FAIL e17_saida got %0h want 1", saida); end
      step(15);
      n_cmp++; if (estado !== 3'd2) begin n_err++; $display("FAIL e32_estado got %0d want 2", estado); end
      step(1);
      n_cmp++; if (estado !== 3'd4) begin n_err++; $display("FAIL e33_estado got %0d want 4", estado); end
      n_cmp++; if (desliga_luz !== 2'b01) begin n_err++; $display("FAIL e33_desliga got %0h want 1", desliga_luz); end
      n_cmp++; if (saida !== 1'b0) begin n_err++; $display("FAIL e33_saida got %0h want 0", saida); end
      n_cmp++; if (alerta !== 1'b1) begin n_err++; $display("FAIL e33_alerta got %0h want 1", alerta); end
      farol = 2'b11;
      step(3);
      n_cmp++; if (desliga_luz !== 2'b01) begin n_err++; $display("FAIL hold_desliga got %0h want 1", desliga_luz); end
      n_cmp++; if (estado !== 3'd4) begin n_err++; $display("FAIL hold_estado got %0d want 4", estado); end
      porta = 1'b1; chave = 1'b1;
      step(1);
      n_cmp++; if (estado !== 3'd0) begin n_err++; $display("FAIL off_estado got %0d want 0", estado); end
      n_cmp++; if (desliga_luz !== 2'b00) begin n_err++; $display("FAIL off_desliga got %0h want 0", desliga_luz); end
      n_cmp++; if (alerta !== 1'b0) begin n_err++; $display("FAIL off_alerta got %0h want 0", alerta); end
   endtask

   task automatic test_silence();
      farol = 2'b01; porta = 1'b0; chave = 1'b1;
      step(13);
      n_cmp++; if (estado !== 3'd2) begin n_err++; $display("FAIL s13_estado got %0d want 2", estado); end
      silenciar = 1'b1;
      step(1);
      silenciar = 1'b0;
      n_cmp++; if (estado !== 3'd3) begin n_err++; $display("FAIL s14_estado got %0d want 3", estado); end
      n_cmp++; if (saida !== 1'b0) begin n_err++; $display("FAIL s14_saida got %0h want 0", saida); end
      n_cmp++; if (alerta !== 1'b1) begin n_err++; $display("FAIL s14_alerta got %0h want 1", alerta); end
      step(30);
      n_cmp++; if (estado !== 3'd3) begin n_err++; $display("FAIL s44_estado got %0d want 3", estado); end
      n_cmp++; if (desliga_luz !== 2'b00) begin n_err++; $display("FAIL s44_desliga got %0h want 0", desliga_luz); end
      silenciar = 1'b1;
      step(1);
      silenciar = 1'b0;
      n_cmp++; if (estado !== 3'd3) begin n_err++; $display("FAIL s_again_estado got %0d want 3", estado); end
      porta = 1'b1;
      step(1);
      n_cmp++; if (estado !== 3'd0) begin n_err++; $display("FAIL s_drop_estado got %0d want 0", estado); end
      n_cmp++; if (alerta !== 1'b0) begin n_err++; $display("FAIL s_drop_alerta got %0h want 0", alerta); end
   endtask

   task automatic test_silence_vs_limit();
      porta = 1'b0;
      step(32);
      n_cmp++; if (estado !== 3'd2) begin n_err++; $display("FAIL tie32_estado got %0d want 2", estado); end
      silenciar = 1'b1;
      step(1);
      silenciar = 1'b0;
      n_cmp++; if (estado !== 3'd3) begin n_err++; $display("FAIL tie33_estado got %0d want 3", estado); end
      n_cmp++; if (desliga_luz !== 2'b00) begin n_err++; $display("FAIL tie33_desliga got %0h want 0", desliga_luz); end
      porta = 1'b1;
      step(1);
      n_cmp++; if (estado !== 3'd0) begin n_err++; $display("FAIL tie_drop_estado got %0d want 0", estado); end
   endtask

   task automatic test_glitch();
      logic seen;
      seen = 1'b0;
      porta = 1'b0; chave = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (saida || alerta) seen = 1'b1;
      end
      n_cmp++; if (estado !== 3'd1) begin n_err++; $display("FAIL g_estado got %0d want 1", estado); end
      porta = 1'b1;
      step(1);
      if (saida || alerta) seen = 1'b1;
      n_cmp++; if (estado !== 3'd0) begin n_err++; $display("FAIL g_drop_estado got %0d want 0", estado); end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL g_quiet got %0h want 0", seen); end
   endtask

   task automatic test_reset_mid();
      porta = 1'b0;
      step(9);
      n_cmp++; if (saida !== 1'b1) begin n_err++; $display("FAIL m9_saida got %0h want 1", saida); end
      rst_n = 1'b0;
      step(1);
      n_cmp++; if (estado !== 3'd0) begin n_err++; $display("FAIL mr_estado got %0d want 0", estado); end
      n_cmp++; if (saida !== 1'b0) begin n_err++; $display("FAIL mr_saida got %0h want 0", saida); end
      n_cmp++; if (alerta !== 1'b0) begin n_err++; $display("FAIL mr_alerta got %0h want 0", alerta); end
      n_cmp++; if (desliga_luz !== 2'b00) begin n_err++; $display("FAIL mr_desliga got %0h want 0", desliga_luz); end
      rst_n = 1'b1;
      step(1);
      n_cmp++; if (estado !== 3'd1) begin n_err++; $display("FAIL mr1_estado got %0d want 1", estado); end
      step(7);
      n_cmp++; if (estado !== 3'd1) begin n_err++; $display("FAIL mr8_estado got %0d want 1", estado); end
      step(1);
      n_cmp++; if (estado !== 3'd2) begin n_err++; $display("FAIL mr9_estado got %0d want 2", estado); end
      n_cmp++; if (saida !== 1'b1) begin n_err++; $display("FAIL mr9_saida got %0h want 1", saida); end
      porta = 1'b1;
      step(1);
   endtask

   initial begin
      test_reset();
      test_beep_limit();
      test_silence();
      test_silence_vs_limit();
      test_glitch();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
